// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: instruction-memory request/response, redirect input and decode-side FIFO head.
interface fetch_unit_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
    logic        instr_ready;

    modport master (
        input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
        output imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc_plus4
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc_plus4
    );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch with a DEPTH-entry prefetch FIFO and redirect flush.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
);
    localparam int         AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    logic [1:0]    r_state;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_pend_pc;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [31:0]   r_pc_mem   [DEPTH];
    logic [31:0]   r_data_mem [DEPTH];

    logic        w_req;
    logic        w_fire;
    logic        w_push;
    logic        w_pop;
    logic        w_valid;
    logic [31:0] w_redir_pc;
    logic [31:0] w_head_pc;

    // Reset is folded into the request so the bus is quiet while reset is held.
    assign w_req      = reset && (r_state == IDLE) && (r_count < FULL) && !bus.redirect_valid;
    assign w_fire     = w_req && bus.imem_gnt;
    assign w_push     = (r_state == WAIT) && bus.imem_rvalid && !bus.redirect_valid;
    assign w_valid    = (r_count != '0);
    assign w_pop      = w_valid && bus.instr_ready && !bus.redirect_valid;
    assign w_redir_pc = bus.redirect_pc & 32'hFFFF_FFFC;
    assign w_head_pc  = r_pc_mem[r_rptr];

    assign bus.imem_req       = w_req;
    assign bus.imem_addr      = reset ? r_fetch_pc : 32'h0;
    assign bus.instr_valid    = w_valid;
    assign bus.instr          = w_valid ? r_data_mem[r_rptr] : 32'h0;
    assign bus.instr_pc       = w_valid ? w_head_pc : 32'h0;
    assign bus.instr_pc_plus4 = w_valid ? (w_head_pc + 32'd4) : 32'h0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_pend_pc  <= 32'h0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            case (r_state)
                IDLE:    if (w_fire) r_state <= WAIT;
                WAIT: begin
                    // A redirect discards the response whether it lands now or later.
                    if (bus.redirect_valid)   r_state <= bus.imem_rvalid ? IDLE : DROP;
                    else if (bus.imem_rvalid) r_state <= IDLE;
                end
                DROP:    if (bus.imem_rvalid) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase

            if (w_fire) r_pend_pc <= r_fetch_pc;

            if (bus.redirect_valid) begin
                r_fetch_pc <= w_redir_pc;
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_count    <= '0;
            end else begin
                if (w_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_push) r_wptr <= r_wptr + AW'(1);
                if (w_pop)  r_rptr <= r_rptr + AW'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + (AW+1)'(1);
                    2'b01:   r_count <= r_count - (AW+1)'(1);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wptr]   <= r_pend_pc;
            r_data_mem[r_wptr] <= bus.imem_rdata;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic against a queue-based model.
module tb_fetch_unit;
    localparam logic [31:0] RPC   = 32'h0000_0040;
    localparam int          DEPTH = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    int          checks = 0;
    int          errors = 0;
    ent_t        m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_pend;
    int          m_out;       // 0 nothing outstanding, 1 response wanted, 2 response to drop
    int          cd;          // memory agent: cycles until rvalid
    int          lat;
    logic [31:0] cd_data;
    bit          rnd_mode = 1'b0;

    task automatic mdl_reset();
        m_pc = RPC; m_pend = 32'h0; m_out = 0; m_q.delete(); cd = 0;
    endtask

    function automatic bit m_req();
        return (m_out == 0) && (m_q.size() < DEPTH) && !bus.redirect_valid;
    endfunction

    task automatic pre();
        bus.imem_rvalid = (cd == 1);
        bus.imem_rdata  = (cd == 1) ? cd_data : $urandom();
        if (rnd_mode && cd == 0 && $urandom_range(19, 0) == 0) bus.imem_rvalid = 1'b1;
    endtask

    // Called at the negedge after checks: advance model and memory agent, then move past the edge.
    task automatic post();
        bit   fire;
        bit   pop;
        ent_t e;
        fire = m_req() && bus.imem_gnt;
        pop  = (m_q.size() != 0) && bus.instr_ready;
        if (bus.redirect_valid) begin
            m_q.delete();
            m_pc = bus.redirect_pc & 32'hFFFF_FFFC;
            if (m_out != 0) m_out = bus.imem_rvalid ? 0 : 2;
        end else begin
            if (pop) m_q.delete(0);
            if (m_out == 1 && bus.imem_rvalid) begin
                e.pc = m_pend; e.data = bus.imem_rdata; m_q.push_back(e); m_out = 0;
            end else if (m_out == 2 && bus.imem_rvalid) begin
                m_out = 0;
            end else if (fire) begin
                m_out = 1; m_pend = m_pc; m_pc = m_pc + 32'd4;
            end
        end
        if (cd > 0) cd--;
        if (bus.imem_req && bus.imem_gnt) begin
            cd      = rnd_mode ? int'($urandom_range(3, 1)) : lat;
            cd_data = bus.imem_addr ^ 32'hA5A5_0000;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0; bus.imem_gnt = 1'b0;
        bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0; bus.instr_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        mdl_reset();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        #2;
        checks++;
        if ({bus.imem_req, bus.imem_addr, bus.instr_valid, bus.instr, bus.instr_pc, bus.instr_pc_plus4} !== '0) begin
            errors++; $display("FAIL reset_outputs: got req=%0b addr=%h v=%0b instr=%h pc=%h pc4=%h want all 0",
                bus.imem_req, bus.imem_addr, bus.instr_valid, bus.instr, bus.instr_pc, bus.instr_pc_plus4);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        mdl_reset();
        pre(); @(negedge clk);
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== RPC) begin
            errors++; $display("FAIL release_req: got req=%0b addr=%h want 1 %h", bus.imem_req, bus.imem_addr, RPC);
        end
        post();
    endtask

    task automatic test_stream();
        logic [31:0] epc;
        bit          ev;
        bus.imem_gnt = 1'b1; bus.instr_ready = 1'b1; lat = 1;
        for (int c = 0; c < 12; c++) begin
            pre(); @(negedge clk);
            ev  = (c >= 2) && (c % 2 == 0);
            epc = RPC + 32'(4 * ((c - 2) / 2));
            checks++;
            if (bus.instr_valid !== ev) begin
                errors++; $display("FAIL stream_valid c=%0d: got %0b want %0b", c, bus.instr_valid, ev);
            end else if (ev) begin
                checks++;
                if (bus.instr_pc !== epc || bus.instr !== (epc ^ 32'hA5A5_0000) || bus.instr_pc_plus4 !== epc + 32'd4) begin
                    errors++; $display("FAIL stream_head c=%0d: got pc=%h instr=%h pc4=%h want pc=%h", c,
                        bus.instr_pc, bus.instr, bus.instr_pc_plus4, epc);
                end
            end else begin
                checks++;
                if ({bus.instr, bus.instr_pc, bus.instr_pc_plus4} !== '0) begin
                    errors++; $display("FAIL stream_zero c=%0d: got instr=%h pc=%h pc4=%h want 0", c,
                        bus.instr, bus.instr_pc, bus.instr_pc_plus4);
                end
            end
            post();
        end
    endtask

    task automatic test_backpressure();
        int grants = 0;
        do_reset();
        bus.imem_gnt = 1'b1; bus.instr_ready = 1'b0; lat = 1;
        for (int c = 0; c < 10; c++) begin
            pre(); @(negedge clk);
            if (bus.imem_req && bus.imem_gnt) grants++;
            if (c >= 4) begin
                checks++;
                if (bus.imem_req !== 1'b0) begin
                    errors++; $display("FAIL bp_req_off c=%0d: got %0b want 0", c, bus.imem_req);
                end
            end
            post();
        end
        checks++;
        if (grants != DEPTH) begin
            errors++; $display("FAIL bp_grants: got %0d want %0d", grants, DEPTH);
        end
        bus.instr_ready = 1'b1;
        pre(); @(negedge clk);
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h40 || bus.imem_req !== 1'b0) begin
            errors++; $display("FAIL bp_first: got v=%0b pc=%h req=%0b want 1 00000040 0",
                bus.instr_valid, bus.instr_pc, bus.imem_req);
        end
        post();
        pre(); @(negedge clk);
        checks++;
        if (bus.instr_pc !== 32'h44 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h48) begin
            errors++; $display("FAIL bp_second: got pc=%h req=%0b addr=%h want 00000044 1 00000048",
                bus.instr_pc, bus.imem_req, bus.imem_addr);
        end
        post();
    endtask

    task automatic test_gnt_stall();
        do_reset();
        bus.imem_gnt = 1'b0; bus.instr_ready = 1'b1; lat = 1;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) bus.imem_gnt = 1'b1;
            pre(); @(negedge clk);
            checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== RPC) begin
                errors++; $display("FAIL stall_hold c=%0d: got req=%0b addr=%h want 1 %h", c, bus.imem_req, bus.imem_addr, RPC);
            end
            post();
        end
        pre(); @(negedge clk);
        checks++;
        if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
            errors++; $display("FAIL stall_wait: got req=%0b v=%0b want 0 0", bus.imem_req, bus.instr_valid);
        end
        post();
        pre(); @(negedge clk);
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== RPC) begin
            errors++; $display("FAIL stall_data: got v=%0b pc=%h want 1 %h", bus.instr_valid, bus.instr_pc, RPC);
        end
        post();
    endtask

    task automatic test_redirect();
        do_reset();
        bus.imem_gnt = 1'b1; bus.instr_ready = 1'b0; lat = 1;
        pre(); @(negedge clk); post();
        pre(); @(negedge clk); post();
        lat = 3;
        pre(); @(negedge clk); post();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h1000_0003;
        pre(); @(negedge clk);
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0) begin
            errors++; $display("FAIL redir_cycle: got v=%0b req=%0b want 1 0", bus.instr_valid, bus.imem_req);
        end
        post();
        bus.redirect_valid = 1'b0;
        pre(); @(negedge clk);
        checks++;
        if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
            errors++; $display("FAIL redir_flush: got v=%0b req=%0b want 0 0", bus.instr_valid, bus.imem_req);
        end
        post();
        pre(); @(negedge clk);
        checks++;
        if (bus.imem_rvalid !== 1'b1 || bus.imem_req !== 1'b0) begin
            errors++; $display("FAIL redir_drop: got rvalid=%0b req=%0b want 1 0", bus.imem_rvalid, bus.imem_req);
        end
        lat = 1;
        post();
        pre(); @(negedge clk);
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h1000_0000 || bus.instr_valid !== 1'b0) begin
            errors++; $display("FAIL redir_target: got req=%0b addr=%h v=%0b want 1 10000000 0",
                bus.imem_req, bus.imem_addr, bus.instr_valid);
        end
        post();
        pre(); @(negedge clk); post();
        pre(); @(negedge clk);
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h1000_0000 || bus.instr !== 32'hB5A5_0000) begin
            errors++; $display("FAIL redir_data: got v=%0b pc=%h instr=%h want 1 10000000 b5a50000",
                bus.instr_valid, bus.instr_pc, bus.instr);
        end
        post();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h2000_0006;
        pre(); @(negedge clk);
        checks++;
        if (bus.imem_rvalid !== 1'b1 || bus.imem_req !== 1'b0) begin
            errors++; $display("FAIL redir_same_rvalid: got rvalid=%0b req=%0b want 1 0", bus.imem_rvalid, bus.imem_req);
        end
        post();
        bus.redirect_valid = 1'b0; bus.imem_gnt = 1'b0;
        pre(); @(negedge clk);
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h2000_0004 || bus.instr_valid !== 1'b0) begin
            errors++; $display("FAIL redir_straight_idle: got req=%0b addr=%h v=%0b want 1 20000004 0",
                bus.imem_req, bus.imem_addr, bus.instr_valid);
        end
        post();
    endtask

    task automatic test_wrap();
        do_reset();
        bus.imem_gnt = 1'b0; bus.instr_ready = 1'b1; lat = 1;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
        pre(); @(negedge clk); post();
        bus.redirect_valid = 1'b0; bus.imem_gnt = 1'b1;
        pre(); @(negedge clk);
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_addr: got req=%0b addr=%h want 1 fffffffc", bus.imem_req, bus.imem_addr);
        end
        post();
        pre(); @(negedge clk); post();
        pre(); @(negedge clk);
        checks++;
        if (bus.instr_pc !== 32'hFFFF_FFFC || bus.instr_pc_plus4 !== 32'h0 || bus.instr !== 32'h5A5A_FFFC ||
            bus.imem_addr !== 32'h0) begin
            errors++; $display("FAIL wrap_first: got pc=%h pc4=%h instr=%h addr=%h want fffffffc 0 5a5afffc 0",
                bus.instr_pc, bus.instr_pc_plus4, bus.instr, bus.imem_addr);
        end
        post();
        pre(); @(negedge clk); post();
        pre(); @(negedge clk);
        checks++;
        if (bus.instr_pc !== 32'h0 || bus.instr_pc_plus4 !== 32'h4 || bus.instr !== 32'hA5A5_0000) begin
            errors++; $display("FAIL wrap_second: got pc=%h pc4=%h instr=%h want 0 4 a5a50000",
                bus.instr_pc, bus.instr_pc_plus4, bus.instr);
        end
        post();
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.imem_gnt = 1'b1; bus.instr_ready = 1'b0; lat = 1;
        pre(); @(negedge clk); post();
        pre(); @(negedge clk); post();
        lat = 2;
        pre(); @(negedge clk); post();
        pre(); #2;
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.imem_addr !== 32'h48) begin
            errors++; $display("FAIL areset_pre: got v=%0b addr=%h want 1 00000048", bus.instr_valid, bus.imem_addr);
        end
        reset = 1'b0; #1;
        checks++;
        if ({bus.imem_req, bus.imem_addr, bus.instr_valid, bus.instr, bus.instr_pc, bus.instr_pc_plus4} !== '0) begin
            errors++; $display("FAIL areset_zero: got req=%0b addr=%h v=%0b instr=%h pc=%h pc4=%h want all 0",
                bus.imem_req, bus.imem_addr, bus.instr_valid, bus.instr, bus.instr_pc, bus.instr_pc_plus4);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        mdl_reset();
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== RPC) begin
            errors++; $display("FAIL areset_release: got req=%0b addr=%h want 1 %h", bus.imem_req, bus.imem_addr, RPC);
        end
        post();
        pre(); @(negedge clk);
        checks++;
        if (bus.instr_valid !== 1'b0) begin
            errors++; $display("FAIL areset_stray: got v=%0b want 0", bus.instr_valid);
        end
        post();
    endtask

    task automatic test_random();
        ent_t h;
        do_reset();
        rnd_mode = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            bus.imem_gnt       = 1'($urandom_range(1, 0));
            bus.instr_ready    = ($urandom_range(9, 0) < 6);
            bus.redirect_valid = ($urandom_range(15, 0) == 0);
            bus.redirect_pc    = ($urandom_range(7, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom();
            pre(); @(negedge clk);
            checks++;
            if (bus.imem_req !== m_req() || (m_req() && bus.imem_addr !== m_pc)) begin
                errors++; $display("FAIL rnd_req c=%0d: got req=%0b addr=%h want req=%0b addr=%h",
                    c, bus.imem_req, bus.imem_addr, m_req(), m_pc);
            end
            checks++;
            if (m_q.size() != 0) begin
                h = m_q[0];
                if (bus.instr_valid !== 1'b1 || bus.instr !== h.data || bus.instr_pc !== h.pc ||
                    bus.instr_pc_plus4 !== h.pc + 32'd4) begin
                    errors++; $display("FAIL rnd_head c=%0d: got v=%0b instr=%h pc=%h pc4=%h want 1 %h %h %h",
                        c, bus.instr_valid, bus.instr, bus.instr_pc, bus.instr_pc_plus4, h.data, h.pc, h.pc + 32'd4);
                end
            end else if ({bus.instr_valid, bus.instr, bus.instr_pc, bus.instr_pc_plus4} !== '0) begin
                errors++; $display("FAIL rnd_empty c=%0d: got v=%0b instr=%h pc=%h pc4=%h want all 0",
                    c, bus.instr_valid, bus.instr, bus.instr_pc, bus.instr_pc_plus4);
            end
            post();
        end
        rnd_mode = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_gnt_stall();
        test_redirect();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
